stream_window: RTL and testbench
================================

STREAM_WINDOW -- requirements
Module: stream_window

Interface
REQ-001 The block SHALL expose parameter KERNEL_SIZE, default 3, window edge length (odd, 3..7).
REQ-002 The block SHALL expose parameter ROW_WIDTH, default 640, pixels per row (>= KERNEL_SIZE).
REQ-003 The block SHALL expose parameter NUM_ROWS, default 480, rows per frame (>= KERNEL_SIZE).
REQ-004 The block SHALL expose parameter WORD_SIZE, default 8, signed pixel width.
REQ-005 The block SHALL have port clk, input, 1 bit, clock, all state on rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-007 The block SHALL have port pixel_in, input, WORD_SIZE bits, signed pixel, raster order.
REQ-008 The block SHALL have port pixel_valid, input, 1 bit; pixel_in is accepted on a rising edge where it is 1.
REQ-009 The block SHALL have port sof, input, 1 bit, start-of-frame, qualified by pixel_valid.
REQ-010 The block SHALL have port window, output, KERNEL_SIZE x KERNEL_SIZE x WORD_SIZE signed, [i][j] = row i, column j, [0][0] oldest.
REQ-011 The block SHALL have port window_valid, output, 1 bit, window holds a complete in-frame kernel.
REQ-012 The block SHALL have ports out_row/out_col, output, $clog2(NUM_ROWS)/$clog2(ROW_WIDTH) bits, frame coordinates of window[0][0].
REQ-013 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse with the last window of a frame.

Function
REQ-014 Counters col (0..ROW_WIDTH-1) and row (0..NUM_ROWS-1) SHALL advance only on an accepted pixel; col wraps to 0 and increments row; at (NUM_ROWS-1, ROW_WIDTH-1), both wrap to 0.
REQ-015 An accepted pixel with sof=1 SHALL be treated as (0,0), regardless of the counters, and the counters SHALL then advance to (0,1).
REQ-016 Cycles without pixel_valid SHALL hold all window, line-buffer and counter state unchanged, and window_valid SHALL be 0 on them.
REQ-017 KERNEL_SIZE-1 line buffers, each ROW_WIDTH deep, addressed by col, SHALL hold the previous rows; an accepted pixel at (r,c) reads the column-c entries of rows r-1..r-K+1 and writes the new column in the same cycle (read-before-write).
REQ-018 After accepting pixel (r,c), on the next cycle window[i][j] SHALL equal pixel(r-K+1+i, c-K+1+j) (latency 1 cycle).
REQ-019 window_valid SHALL be 1 for exactly one cycle, one cycle after accepting (r,c), if r >= KERNEL_SIZE-1 and c >= KERNEL_SIZE-1; otherwise it SHALL be 0; windows straddling a row wrap SHALL never be flagged valid.
REQ-020 out_row = r-K+1 and out_col = c-K+1 SHALL be registered alongside window_valid; their values are don't-care when window_valid=0.
REQ-021 frame_done SHALL pulse coincident with the window_valid for pixel (NUM_ROWS-1, ROW_WIDTH-1); a frame interrupted by sof SHALL NOT pulse.
REQ-022 Each complete frame SHALL produce exactly (NUM_ROWS-K+1)*(ROW_WIDTH-K+1) valid windows.
REQ-023 Back-to-back frames (new frame's first pixel on the cycle after the previous frame's last pixel) SHALL be supported with no bubble.

Reset
REQ-024 Reset SHALL set row and col to 0, window to all zeros, and window_valid, frame_done, out_row and out_col to 0.
REQ-025 Line-buffer contents SHALL NOT be reset; window_valid gating SHALL guarantee stale data never appears in a valid window.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the next accepted pixel is (0,0) whether or not sof is set.

Structure
REQ-027 A shared package window_pkg SHALL hold the coordinate-width functions and the pixel typedef parameterised by WORD_SIZE.
REQ-028 Each line buffer SHALL be one instance of sub-module line_ram: single-port, read-before-write, ROW_WIDTH x WORD_SIZE, with write enable = accepted pixel; instances are chained by generate.

Verification
REQ-029 The bench SHALL drive K=3, 5x5 frame, pixels 1..25 continuous, sof on 1 -> first window_valid after pixel 13, window rows {1,2,3},{6,7,8},{11,12,13}, out=(0,0); exactly 9 valid windows; frame_done with window {13..25 corner}.
REQ-030 The bench SHALL repeat REQ-029 with pixel_valid randomly low 50% of cycles -> an identical window/coordinate sequence, and window_valid never high on idle cycles.
REQ-031 The bench SHALL drive two back-to-back 5x5 frames (26..50 second) -> 18 valid windows, two frame_done pulses, and the second frame's first window = {26,27,28},{31,32,33},{36,37,38}.
REQ-032 The bench SHALL assert sof at pixel 17 of frame one, then send a full frame -> no frame_done for the aborted frame, and 9 correct windows from the new frame.
REQ-033 The bench SHALL assert reset after pixel 20, then send a full frame without sof -> window all zeros and window_valid=0 during reset, then 9 correct windows.
REQ-034 The bench SHALL drive K=5, ROW_WIDTH=10, NUM_ROWS=6 -> 12 valid windows, and a final window[4][4] = 60.

Source files
------------

// File: rtl/window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_pkg
// Description : Coordinate-width helpers and pixel type for stream_window.
// Revision    : 1.0 - initial release
// ============================================================================
package window_pkg;

    localparam int unsigned c_default_word_size = 8;

    typedef logic signed [c_default_word_size-1:0] pixel_t;

    function automatic int unsigned coord_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned row_coord_w(input int unsigned num_rows);
        return coord_width(num_rows);
    endfunction

    function automatic int unsigned col_coord_w(input int unsigned row_width);
        return coord_width(row_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_ram
// Description : Single-port row buffer, asynchronous read, read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
module line_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are deliberately not reset; stale rows are masked downstream.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/stream_window.sv
`default_nettype none
// ============================================================================
// Module      : stream_window
// Description : KxK sliding window over a raster pixel stream, 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_window
    import window_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ROW_WIDTH   = 640,
    parameter int unsigned NUM_ROWS    = 480,
    parameter int unsigned WORD_SIZE   = 8
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic signed [WORD_SIZE-1:0]                            pixel_in,
    input  logic                                                   pixel_valid,
    input  logic                                                   sof,
    output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] window,
    output logic                                                   window_valid,
    output logic [row_coord_w(NUM_ROWS)-1:0]                       out_row,
    output logic [col_coord_w(ROW_WIDTH)-1:0]                      out_col,
    output logic                                                   frame_done
);

    localparam int unsigned c_rw = row_coord_w(NUM_ROWS);
    localparam int unsigned c_cw = col_coord_w(ROW_WIDTH);

    localparam logic [c_rw-1:0] c_last_row = c_rw'(NUM_ROWS - 1);
    localparam logic [c_cw-1:0] c_last_col = c_cw'(ROW_WIDTH - 1);
    localparam logic [c_rw-1:0] c_k1_row   = c_rw'(KERNEL_SIZE - 1);
    localparam logic [c_cw-1:0] c_k1_col   = c_cw'(KERNEL_SIZE - 1);

    logic [c_rw-1:0] r_row;
    logic [c_cw-1:0] r_col;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] r_window;
    logic            r_valid;
    logic            r_done;
    logic [c_rw-1:0] r_orow;
    logic [c_cw-1:0] r_ocol;

    logic [c_rw-1:0] w_pr;
    logic [c_cw-1:0] w_pc;
    logic [c_rw-1:0] w_next_row;
    logic [c_cw-1:0] w_next_col;
    logic            w_last_col;
    logic            w_in_kernel;
    logic            w_last;
    logic [KERNEL_SIZE-1:0][WORD_SIZE-1:0]                  w_column;
    logic [KERNEL_SIZE-2:0][WORD_SIZE-1:0]                  w_ram_rd;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] w_win_next;

    // A start-of-frame pixel is pinned to (0,0) regardless of the counters.
    assign w_pr        = sof ? '0 : r_row;
    assign w_pc        = sof ? '0 : r_col;
    assign w_last_col  = (w_pc == c_last_col);
    assign w_next_col  = w_last_col ? '0 : w_pc + c_cw'(1);
    assign w_next_row  = !w_last_col ? w_pr :
                         (w_pr == c_last_row) ? '0 : w_pr + c_rw'(1);
    assign w_in_kernel = (w_pr >= c_k1_row) && (w_pc >= c_k1_col);
    assign w_last      = (w_pr == c_last_row) && w_last_col;

    // Row buffers cascade: buffer k holds row r-1-k and feeds buffer k+1.
    assign w_column[KERNEL_SIZE-1] = pixel_in;

    for (genvar gk = 0; gk < KERNEL_SIZE - 1; gk++) begin : g_line
        logic [WORD_SIZE-1:0] w_wdata;

        if (gk == 0) begin : g_first
            assign w_wdata = pixel_in;
        end else begin : g_rest
            assign w_wdata = w_ram_rd[gk-1];
        end

        line_ram #(
            .DEPTH (ROW_WIDTH),
            .WIDTH (WORD_SIZE),
            .AW    (c_cw)
        ) u_line_ram (
            .clk     (clk),
            .i_we    (pixel_valid),
            .i_addr  (w_pc),
            .i_wdata (w_wdata),
            .o_rdata (w_ram_rd[gk])
        );

        assign w_column[KERNEL_SIZE-2-gk] = w_ram_rd[gk];
    end

    for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < KERNEL_SIZE - 1; gj++) begin : g_shift
            assign w_win_next[gi][gj] = r_window[gi][gj+1];
        end
        assign w_win_next[gi][KERNEL_SIZE-1] = w_column[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row    <= '0;
            r_col    <= '0;
            r_window <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_orow   <= '0;
            r_ocol   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (pixel_valid) begin
                r_window <= w_win_next;
                r_valid  <= w_in_kernel;
                r_done   <= w_last;
                r_orow   <= w_pr - c_k1_row;
                r_ocol   <= w_pc - c_k1_col;
                r_row    <= w_next_row;
                r_col    <= w_next_col;
            end
        end
    end

    assign window       = r_window;
    assign window_valid = r_valid;
    assign frame_done   = r_done;
    assign out_row      = r_orow;
    assign out_col      = r_ocol;

endmodule
`default_nettype wire

// File: tb/tb_stream_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_window
// Description : Self-checking bench for stream_window (K=3 5x5, K=5 10x6).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stream_window;

    localparam int WS = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic signed [WS-1:0] px_a = '0, px_b = '0;
    logic v_a = 1'b0, v_b = 1'b0, sof_a = 1'b0, sof_b = 1'b0;

    logic signed [2:0][2:0][WS-1:0] win_a;
    logic signed [4:0][4:0][WS-1:0] win_b;
    logic       wv_a, wv_b, fd_a, fd_b;
    logic [2:0] orow_a, ocol_a, orow_b;
    logic [3:0] ocol_b;

    stream_window #(.KERNEL_SIZE(3), .ROW_WIDTH(5), .NUM_ROWS(5), .WORD_SIZE(WS)) dut_a (
        .clk(clk), .reset(reset), .pixel_in(px_a), .pixel_valid(v_a), .sof(sof_a),
        .window(win_a), .window_valid(wv_a), .out_row(orow_a), .out_col(ocol_a),
        .frame_done(fd_a)
    );

    stream_window #(.KERNEL_SIZE(5), .ROW_WIDTH(10), .NUM_ROWS(6), .WORD_SIZE(WS)) dut_b (
        .clk(clk), .reset(reset), .pixel_in(px_b), .pixel_valid(v_b), .sof(sof_b),
        .window(win_b), .window_valid(wv_b), .out_row(orow_b), .out_col(ocol_b),
        .frame_done(fd_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_win   = 0;
    int n_done  = 0;

    // Reference image and raster position, keyed by (dut, row, col).
    logic [WS-1:0] img [int];
    int m_row [int];
    int m_col [int];

    function automatic int kk(input int sel); return (sel == 0) ? 3 : 5;  endfunction
    function automatic int ww(input int sel); return (sel == 0) ? 5 : 10; endfunction
    function automatic int hh(input int sel); return (sel == 0) ? 5 : 6;  endfunction
    function automatic int key(input int sel, input int r, input int c);
        return sel * 10000 + r * 100 + c;
    endfunction

    function automatic logic [WS-1:0] win_el(input int sel, input int i, input int j);
        if (sel == 0) return win_a[i[1:0]][j[1:0]];
        return win_b[i[2:0]][j[2:0]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compares the live window against base + i*ROW_WIDTH + j.
    task automatic chk_block(input int sel, input string tag, input int base);
        bit ok = 1'b1;
        logic [WS-1:0] o, e, bo, be;
        bo = '0; be = '0;
        for (int i = 0; i < kk(sel); i++) begin
            for (int j = 0; j < kk(sel); j++) begin
                o = win_el(sel, i, j);
                e = WS'(base + i * ww(sel) + j);
                if (ok && o !== e) begin ok = 1'b0; bo = o; be = e; end
            end
        end
        n_tests++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, bo, be);
        end
    endtask

    task automatic step(input int sel, input logic [WS-1:0] pix, input logic s, input logic v);
        bit exp_valid = 1'b0, exp_done = 1'b0, ok = 1'b1;
        int r = 0, c = 0, k;
        logic [WS-1:0] o, e, bo, be;
        logic obs_v, obs_d;
        k = kk(sel);
        bo = '0; be = '0;
        if (sel == 0) begin px_a = pix; sof_a = s; v_a = v; end
        else          begin px_b = pix; sof_b = s; v_b = v; end
        @(posedge clk);
        #1;
        v_a = 1'b0; sof_a = 1'b0; v_b = 1'b0; sof_b = 1'b0;
        if (v) begin
            if (s) begin r = 0; c = 0; end
            else   begin r = m_row[sel]; c = m_col[sel]; end
            img[key(sel, r, c)] = pix;
            exp_valid = (r >= k - 1) && (c >= k - 1);
            exp_done  = (r == hh(sel) - 1) && (c == ww(sel) - 1);
            m_row[sel] = r;
            m_col[sel] = c + 1;
            if (m_col[sel] == ww(sel)) begin
                m_col[sel] = 0;
                m_row[sel] = (r + 1 == hh(sel)) ? 0 : r + 1;
            end
        end
        obs_v = (sel == 0) ? wv_a : wv_b;
        obs_d = (sel == 0) ? fd_a : fd_b;
        if (obs_v) n_win++;
        if (obs_d) n_done++;
        chk("window_valid", {31'b0, obs_v}, {31'b0, exp_valid});
        chk("frame_done", {31'b0, obs_d}, {31'b0, exp_done});
        if (exp_valid) begin
            chk("out_row", (sel == 0) ? 32'(orow_a) : 32'(orow_b), 32'(r - k + 1));
            chk("out_col", (sel == 0) ? 32'(ocol_a) : 32'(ocol_b), 32'(c - k + 1));
            for (int i = 0; i < k; i++) begin
                for (int j = 0; j < k; j++) begin
                    o = win_el(sel, i, j);
                    e = img[key(sel, r - k + 1 + i, c - k + 1 + j)];
                    if (ok && o !== e) begin ok = 1'b0; bo = o; be = e; end
                end
            end
            n_tests++;
            assert (ok) else begin
                n_fail++;
                $error("FAIL window_contents: observed %0d expected %0d", bo, be);
            end
        end
    endtask

    // One accepted pixel, optionally preceded by a random idle cycle.
    task automatic send(input int sel, input logic [WS-1:0] pix, input logic s, input bit idle);
        if (idle && $urandom_range(0, 1) == 1) step(sel, WS'($urandom), 1'b0, 1'b0);
        step(sel, pix, s, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        v_a = 1'b0; v_b = 1'b0; sof_a = 1'b0; sof_b = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_win_a_zero", {31'b0, |win_a}, 32'd0);
        chk("rst_win_b_zero", {31'b0, |win_b}, 32'd0);
        chk("rst_wv_a", {31'b0, wv_a}, 32'd0);
        chk("rst_fd_a", {31'b0, fd_a}, 32'd0);
        chk("rst_out_a", {26'b0, orow_a, ocol_a}, 32'd0);
        chk("rst_wv_b", {31'b0, wv_b}, 32'd0);
        reset = 1'b0;
        m_row[0] = 0; m_col[0] = 0; m_row[1] = 0; m_col[1] = 0;
    endtask

    initial begin
        m_row[0] = 0; m_col[0] = 0; m_row[1] = 0; m_col[1] = 0;
        do_reset(3);

        // Directed 5x5 frame 1..25, continuous.
        n_win = 0; n_done = 0;
        for (int p = 1; p <= 12; p++) send(0, WS'(p), p == 1, 1'b0);
        send(0, 8'd13, 1'b0, 1'b0);
        chk_block(0, "first_window", 1);
        chk("first_out", {26'b0, orow_a, ocol_a}, 32'd0);
        for (int p = 14; p <= 25; p++) send(0, WS'(p), 1'b0, 1'b0);
        chk_block(0, "corner_window", 13);
        chk("frame1_wins", n_win, 32'd9);
        chk("frame1_done", n_done, 32'd1);

        // Same frame with random idle cycles.
        n_win = 0; n_done = 0;
        for (int p = 1; p <= 25; p++) send(0, WS'(p), p == 1, 1'b1);
        repeat (3) step(0, 8'd0, 1'b0, 1'b0);
        chk_block(0, "idle_corner", 13);
        chk("idle_wins", n_win, 32'd9);
        chk("idle_done", n_done, 32'd1);

        // Two back-to-back frames.
        n_win = 0; n_done = 0;
        for (int p = 1; p <= 25; p++) send(0, WS'(p), p == 1, 1'b0);
        for (int p = 26; p <= 38; p++) send(0, WS'(p), p == 26, 1'b0);
        chk_block(0, "b2b_first_window", 26);
        for (int p = 39; p <= 50; p++) send(0, WS'(p), 1'b0, 1'b0);
        chk("b2b_wins", n_win, 32'd18);
        chk("b2b_done", n_done, 32'd2);

        // Frame aborted by sof at its 17th pixel.
        n_win = 0; n_done = 0;
        for (int p = 1; p <= 16; p++) send(0, WS'(p), p == 1, 1'b0);
        chk("abort_no_done", n_done, 32'd0);
        n_win = 0;
        for (int p = 0; p < 25; p++) send(0, WS'($urandom), p == 0, 1'b0);
        chk("abort_new_wins", n_win, 32'd9);
        chk("abort_new_done", n_done, 32'd1);

        // Reset mid-frame, then a frame without sof.
        for (int p = 1; p <= 20; p++) send(0, WS'(p), p == 1, 1'b0);
        do_reset(1);
        n_win = 0; n_done = 0;
        for (int p = 0; p < 25; p++) send(0, WS'($urandom), 1'b0, 1'b0);
        chk("post_reset_wins", n_win, 32'd9);
        chk("post_reset_done", n_done, 32'd1);

        // Random frames with random idles, sof only on the first.
        for (int f = 0; f < 3; f++) begin
            n_win = 0; n_done = 0;
            for (int p = 0; p < 25; p++) send(0, WS'($urandom), (f == 0) && (p == 0), 1'b1);
            chk("rand_wins", n_win, 32'd9);
            chk("rand_done", n_done, 32'd1);
        end

        // K=5 on a 10x6 frame.
        n_win = 0; n_done = 0;
        for (int p = 1; p <= 60; p++) send(1, WS'(p), p == 1, 1'b0);
        chk("k5_wins", n_win, 32'd12);
        chk("k5_done", n_done, 32'd1);
        chk("k5_last_44", 32'(win_b[4][4]), 32'd60);
        chk_block(1, "k5_last_window", 16);
        n_win = 0; n_done = 0;
        for (int p = 0; p < 60; p++) send(1, WS'($urandom), 1'b0, 1'b1);
        chk("k5_rand_wins", n_win, 32'd12);
        chk("k5_rand_done", n_done, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
